// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Loads a program into a 32-bit-wide instruction memory from a
//               byte stream (least-significant byte first). While no valid
//               program is present the CPU is held in reset. Once the load
//               completes, the CPU is released and gets the memory address
//               port for instruction fetch.
//
// Ports
//   clk         in   1   single clock, rising edge
//   rst_n       in   1   synchronous active-low reset
//   start       in   1   one-cycle pulse that begins a program load
//   word_count  in   7   words to load (1..DEPTH), sampled on accepted start
//   byte_valid  in   1   byte-stream valid
//   byte_data   in   8   byte-stream data
//   byte_ready  out  1   byte accepted this cycle when byte_valid is high
//   fetch_addr  in   6   CPU instruction word address
//   mem_addr    out  6   instruction-memory word address
//   mem_we      out  1   instruction-memory write enable
//   mem_wdata   out  32  instruction-memory write data
//   cpu_rst_n   out  1   active-low CPU reset, high only in DONE
//   busy        out  1   load in progress
//   done        out  1   program loaded, CPU released
//   err         out  1   load aborted, held until the next start
//
// Revision    : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  word_count,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic [5:0]  fetch_addr,
    output logic [5:0]  mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t          state_q,    state_d;
    logic [5:0]      word_idx_q, word_idx_d;
    logic [5:0]      last_idx_q, last_idx_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [TO_W-1:0] timeout_q,  timeout_d;
    logic [31:0]     asm_q,      asm_d;

    logic            start_ok;
    logic            count_ok;
    logic            byte_acc;
    logic [TO_W-1:0] timeout_inc;

    // start is only honoured when no load is in flight
    assign start_ok    = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                   (state_q == S_ERR));
    assign count_ok    = (word_count != 7'd0) && (word_count <= 7'(DEPTH));
    assign byte_acc    = (state_q == S_RECV) && byte_valid;
    assign timeout_inc = timeout_q + TO_W'(1);

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        last_idx_d = last_idx_q;
        byte_idx_d = byte_idx_q;
        timeout_d  = timeout_q;
        asm_d      = asm_q;

        if (start_ok) begin
            if (count_ok) begin
                state_d    = S_RECV;
                word_idx_d = 6'd0;
                byte_idx_d = 2'd0;
                timeout_d  = '0;
                asm_d      = 32'd0;
                // Storing count-1 keeps the compare 6-bit: 64 maps to 63
                last_idx_d = word_count[5:0] - 6'd1;
            end else begin
                state_d = S_ERR;
            end
        end else begin
            case (state_q)
                S_RECV: begin
                    if (byte_acc) begin
                        timeout_d = '0;
                        case (byte_idx_q)
                            2'd0:    asm_d[7:0]   = byte_data;
                            2'd1:    asm_d[15:8]  = byte_data;
                            2'd2:    asm_d[23:16] = byte_data;
                            default: asm_d[31:24] = byte_data;
                        endcase
                        if (byte_idx_q == 2'd3) begin
                            state_d = S_WRITE;
                        end else begin
                            byte_idx_d = byte_idx_q + 2'd1;
                        end
                    end else begin
                        // Abort on the idle cycle that brings the count to
                        // TIMEOUT; the partial word never reaches WRITE.
                        timeout_d = timeout_inc;
                        if (timeout_inc == TO_W'(TIMEOUT)) begin
                            state_d = S_ERR;
                        end
                    end
                end
                S_WRITE: begin
                    if (word_idx_q == last_idx_q) begin
                        state_d = S_DONE;
                    end else begin
                        word_idx_d = word_idx_q + 6'd1;
                        byte_idx_d = 2'd0;
                        state_d    = S_RECV;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            word_idx_q <= 6'd0;
            last_idx_q <= 6'd0;
            byte_idx_q <= 2'd0;
            timeout_q  <= '0;
            asm_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            last_idx_q <= last_idx_d;
            byte_idx_q <= byte_idx_d;
            timeout_q  <= timeout_d;
            asm_q      <= asm_d;
        end
    end

    // Status outputs decode straight from the registered state
    assign byte_ready = (state_q == S_RECV);
    assign busy       = (state_q == S_RECV) || (state_q == S_WRITE);
    assign mem_we     = (state_q == S_WRITE);
    assign done       = (state_q == S_DONE);
    assign cpu_rst_n  = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign mem_wdata  = asm_q;

    // The CPU owns the address port except while a load is in flight
    assign mem_addr   = busy ? word_idx_q : fetch_addr;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader (DEPTH=64,
//               TIMEOUT=8). Writes are captured into a shadow memory and
//               compared against hand-computed words.
// Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [5:0]  fetch_addr;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    imem_loader #(
        .DEPTH   (64),
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .fetch_addr (fetch_addr),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Write capture
    logic [31:0] shadow [0:63];
    int          wr_cnt       = 0;
    int          overlap      = 0;
    logic [5:0]  last_wr_addr = 6'd0;

    always @(posedge clk) begin
        if (mem_we) begin
            shadow[mem_addr] <= mem_wdata;
            wr_cnt           <= wr_cnt + 1;
            last_wr_addr     <= mem_addr;
            if (byte_ready) overlap <= overlap + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [6:0] wc);
        start      = 1'b1;
        word_count = wc;
        tick();
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 20) begin
            tick();
            n++;
        end
        if (!byte_ready) check_val("byte_ready_wait", byte_ready, 1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check_val(tag, done, 1);
    endtask

    function automatic logic [31:0] pat(input int i);
        return {8'(i), 8'(i + 64), 8'(255 - i), 8'(i * 3)};
    endfunction

    logic [7:0]  b1 [8] = '{8'h83, 8'h20, 8'h00, 8'h00, 8'h03, 8'h21, 8'h50, 8'h00};
    logic [31:0] w3 [3] = '{32'hDEADBEEF, 32'h12345678, 32'hA5C30F96};

    initial begin
        int idx;
        int cyc;
        int wr0;
        logic acc;
        logic [31:0] cur;

        rst_n      = 1'b0;
        start      = 1'b0;
        word_count = 7'd0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        fetch_addr = 6'h2a;

        // ---------------- reset state ----------------
        tick();
        tick();
        check_val("rst_busy", busy, 0);
        check_val("rst_cpu_rst_n", cpu_rst_n, 0);
        check_val("rst_ready", byte_ready, 0);
        rst_n = 1'b1;
        tick();
        check_val("idle_done", done, 0);
        check_val("idle_err", err, 0);
        check_val("idle_we", mem_we, 0);
        check_val("idle_addr", mem_addr, 6'h2a);
        fetch_addr = 6'h15;
        #1;
        check_val("idle_addr_mux", mem_addr, 6'h15);

        // ---------------- basic load, cycle exact ----------------
        start      = 1'b1;
        word_count = 7'd2;
        byte_valid = 1'b1;
        byte_data  = b1[0];
        idx        = 0;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (c == 5) begin
                check_val("basic_we_c5", mem_we, 1);
                check_val("basic_addr_c5", mem_addr, 6'd0);
                check_val("basic_wdata_c5", mem_wdata, 32'h00002083);
            end else if (c == 10) begin
                check_val("basic_we_c10", mem_we, 1);
                check_val("basic_addr_c10", mem_addr, 6'd1);
                check_val("basic_wdata_c10", mem_wdata, 32'h00502103);
            end else if (c == 11) begin
                check_val("basic_done", done, 1);
                check_val("basic_cpu_rst_n", cpu_rst_n, 1);
                check_val("basic_busy_done", busy, 0);
            end else begin
                check_val($sformatf("basic_we_c%0d", c), mem_we, 0);
            end
            if (c == 1) check_val("basic_cpu_held", cpu_rst_n, 0);
            if (c == 6) check_val("basic_recv_addr", mem_addr, 6'd1);
            byte_valid = (idx < 8);
            byte_data  = b1[(idx < 8) ? idx : 7];
            acc        = byte_valid && byte_ready;
            tick();
            if (acc) idx++;
        end
        byte_valid = 1'b0;
        check_val("basic_mem0", shadow[0], 32'h00002083);
        check_val("basic_mem1", shadow[1], 32'h00502103);

        // ---------------- back-pressure, start from DONE ----------------
        wr0 = wr_cnt;
        do_start(7'd3);
        check_val("reload_cpu_rst_n", cpu_rst_n, 0);
        check_val("reload_busy", busy, 1);
        idx = 0;
        cyc = 0;
        while (!done && cyc < 200) begin
            byte_valid = (cyc % 2 == 0);
            cur        = w3[(idx < 12) ? idx / 4 : 2];
            byte_data  = cur[8 * (idx % 4) +: 8];
            acc        = byte_valid && byte_ready;
            tick();
            if (acc) idx++;
            cyc++;
        end
        byte_valid = 1'b0;
        check_val("bp_done", done, 1);
        check_val("bp_bytes", idx, 12);
        check_val("bp_writes", wr_cnt - wr0, 3);
        check_val("bp_mem0", shadow[0], 32'hDEADBEEF);
        check_val("bp_mem1", shadow[1], 32'h12345678);
        check_val("bp_mem2", shadow[2], 32'hA5C30F96);
        check_val("bp_we_in_recv", overlap, 0);

        // ---------------- bad word counts ----------------
        wr0 = wr_cnt;
        do_start(7'd0);
        check_val("bad0_err", err, 1);
        check_val("bad0_cpu_rst_n", cpu_rst_n, 0);
        check_val("bad0_busy", busy, 0);
        tick();
        check_val("bad0_sticky", err, 1);
        do_start(7'd65);
        check_val("bad65_err", err, 1);
        check_val("bad65_cpu_rst_n", cpu_rst_n, 0);
        check_val("bad_no_write", wr_cnt - wr0, 0);
        do_start(7'd1);
        check_val("good_after_err_err", err, 0);
        check_val("good_after_err_busy", busy, 1);
        send_word(32'h0BADF00D);
        wait_done("good_after_err_done");
        check_val("good_after_err_mem", shadow[0], 32'h0BADF00D);

        // ---------------- timeout ----------------
        wr0 = wr_cnt;
        do_start(7'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        for (int i = 0; i < 7; i++) tick();
        check_val("to_err_early", err, 0);
        check_val("to_busy_early", busy, 1);
        tick();
        check_val("to_err", err, 1);
        check_val("to_cpu_rst_n", cpu_rst_n, 0);
        check_val("to_no_write", wr_cnt - wr0, 0);

        // ---------------- reset mid-load ----------------
        wr0 = wr_cnt;
        do_start(7'd2);
        send_word(32'hCAFEF00D);
        send_byte(8'hCC);
        send_byte(8'h33);
        check_val("mid_first_write", wr_cnt - wr0, 1);
        rst_n = 1'b0;
        tick();
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_cpu_rst_n", cpu_rst_n, 0);
        check_val("mid_rst_ready", byte_ready, 0);
        check_val("mid_rst_err", err, 0);
        rst_n = 1'b1;
        tick();
        check_val("mid_idle_cpu_rst_n", cpu_rst_n, 0);
        wr0 = wr_cnt;
        do_start(7'd1);
        send_word(32'h11223344);
        wait_done("mid_restart_done");
        check_val("mid_restart_mem", shadow[0], 32'h11223344);
        check_val("mid_restart_addr", last_wr_addr, 6'd0);
        check_val("mid_restart_writes", wr_cnt - wr0, 1);

        // ---------------- full depth with ignored starts ----------------
        wr0 = wr_cnt;
        do_start(7'd64);
        idx = 0;
        cyc = 0;
        while (!done && cyc < 600) begin
            start      = (cyc % 37 == 3);
            word_count = start ? 7'd5 : 7'd64;
            byte_valid = 1'b1;
            cur        = pat((idx < 256) ? idx / 4 : 63);
            byte_data  = cur[8 * (idx % 4) +: 8];
            acc        = byte_valid && byte_ready;
            tick();
            if (acc) idx++;
            cyc++;
        end
        start      = 1'b0;
        byte_valid = 1'b0;
        check_val("full_done", done, 1);
        check_val("full_cycles", cyc, 320);
        check_val("full_writes", wr_cnt - wr0, 64);
        check_val("full_last_addr", last_wr_addr, 6'd63);
        check_val("full_mem0", shadow[0], pat(0));
        check_val("full_mem31", shadow[31], pat(31));
        check_val("full_mem63", shadow[63], pat(63));
        fetch_addr = 6'h07;
        #1;
        check_val("done_fetch_mux", mem_addr, 6'h07);
        do_start(7'd1);
        check_val("rld_cpu_rst_n", cpu_rst_n, 0);
        check_val("rld_busy", busy, 1);
        check_val("rld_addr", mem_addr, 6'd0);
        send_word(32'h89ABCDEF);
        wait_done("rld_done");
        check_val("rld_mem0", shadow[0], 32'h89ABCDEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
